programmable_sclk_divider: RTL and testbench
============================================

Name: programmable_sclk_divider

Overview:
Parametrised successor to the fixed 100 MHz to 20 MHz serial-clock generator. It derives a registered, glitch-free divided clock s_clk from the system clk, using a divisor that can be changed at run time. It also provides single-cycle rise/fall strobes, so downstream serial logic can stay in the clk domain. Divisor changes are deferred to a period boundary, so s_clk never produces a runt pulse.

Parameters:
CNT_W, 8, width of divisor and internal counter; maximum divisor is 2^CNT_W-1
DEFAULT_DIV, 5, divisor loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1 (5 gives 20 MHz from 100 MHz)

Ports:
clk  input  1  system clock; single clock domain; all logic on its rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; when 0, the divider freezes
div_in  input  CNT_W  requested divisor D
div_load  input  1  one-cycle strobe that samples div_in
s_clk  output  1  divided clock, registered
rise_stb  output  1  1-cycle pulse, asserted in the same cycle s_clk goes 0->1
fall_stb  output  1  1-cycle pulse, asserted in the same cycle s_clk goes 1->0
div_active  output  CNT_W  divisor governing the current period
div_err  output  1  1-cycle pulse on rejected load (div_in < 2)

Behaviour:
- Reset values (rst=1 at an edge):
  - cnt=DEFAULT_DIV-1; s_clk=0; rise_stb=0; fall_stb=0; div_err=0.
  - div_active=DEFAULT_DIV; pending divisor=DEFAULT_DIV; pending-valid cleared.
  - rst overrides all other inputs; reset mid-period discards any pending load.
- Definitions: D=div_active; HI=D-(D>>1), i.e. ceil(D/2), the number of high cycles; low phase = D-HI cycles.
- Each edge with en=1:
  - wrap = (cnt==D-1).
  - cnt_next = wrap ? 0 : cnt+1.
  - cnt <= cnt_next.
  - s_clk <= (cnt_next < HI_eff).
  - rise_stb <= (cnt_next==0).
  - fall_stb <= (cnt_next==HI_eff).
  - HI_eff/D_eff: on a wrap, the period just starting uses the newly applied divisor; otherwise HI_eff=HI.
- First enabled edge after reset: cnt wraps to 0, so s_clk=1 and rise_stb=1 on that edge. There is zero latency from the first en=1 edge to the first rising s_clk.
- Period is exactly D clk cycles. Even D gives 50% duty; odd D is high one extra cycle (D=5: 3 high, 2 low).
- Divisor load:
  - div_load=1 with div_in>=2: the value is stored as pending.
  - Pending is applied at the first wrap edge at or after the load cycle. A load in the same cycle as a wrap applies to the period starting at that edge, via bypass.
  - div_active updates on the applying edge.
  - Multiple loads before a wrap: last one wins.
  - A load whose div_in equals div_active is harmless.
- Invalid load (div_in=0 or 1): div_err=1 for the next cycle only; pending and active divisor are unchanged. An invalid load does not cancel an earlier valid pending value.
- en=0: cnt and s_clk hold; rise_stb=fall_stb=0; loads are still accepted and stored but not applied until an enabled wrap. Re-enabling resumes mid-period from the held cnt.
- Counter arithmetic is unsigned, CNT_W bits. cnt never exceeds D-1, and D-1 never overflows.
- Strobes are never asserted together. No combinational path exists from inputs to outputs.

Test Plan:
- Reset, then en=1 with default D=5 -> s_clk pattern 1,1,1,0,0 repeating; rise_stb every 5 cycles aligned with the 0->1 transition; fall_stb 3 cycles later; div_active=5.
- Mid-period load div_in=4 at cnt=1 -> the current period completes at 5 cycles; from the next wrap the pattern is 1,1,0,0; div_active changes to 4 exactly on the wrap edge.
- Load div_in=2 in the wrap cycle -> the period starting at that edge is 1,0; loading div_in=255 (CNT_W=8) -> 128 high, 127 low.
- Load div_in=0, then div_in=1 -> div_err pulses once per load; divisor stays 5; a valid pending 6 loaded before them still applies at the next wrap.
- en=0 for 7 cycles at cnt=2 -> s_clk is held, strobes stay 0; after re-enable the remaining 2 cycles of the period complete, then normal operation continues.
- rst asserted mid-period with a pending divisor of 3 -> next cycle all outputs are at reset values and div_active=5; with en=1 the next edge gives s_clk=1 and rise_stb=1 at D=5.

Source files
------------

// File: rtl/programmable_sclk_divider.sv
// Run-time programmable clock divider: registered s_clk plus rise/fall strobes in the clk domain.
// A divisor change takes effect only on a period wrap, so s_clk never produces a runt pulse.
module programmable_sclk_divider #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             s_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] div_active,
  output logic             div_err
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_active_q, pend_q;
  logic             pend_vld_q;
  logic             s_clk_q, rise_q, fall_q, err_q;

  logic             load_ok, load_bad, wrap, pend_vld_eff;
  logic [CNT_W-1:0] pend_eff, d_eff, hi_eff;

  // A load in the wrap cycle bypasses the pending register.
  always_comb begin
    load_ok      = div_load && (div_in >= CNT_W'(2));
    load_bad     = div_load && (div_in <  CNT_W'(2));
    pend_vld_eff = load_ok | pend_vld_q;
    pend_eff     = load_ok ? div_in : pend_q;
    wrap         = (cnt_q == div_active_q - CNT_W'(1));
    d_eff        = (wrap && pend_vld_eff) ? pend_eff : div_active_q;
    hi_eff       = d_eff - (d_eff >> 1);
    cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= DEF - CNT_W'(1);
      div_active_q <= DEF;
      pend_q       <= DEF;
      pend_vld_q   <= 1'b0;
      s_clk_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q  <= load_bad;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (en) begin
        cnt_q   <= cnt_d;
        s_clk_q <= (cnt_d < hi_eff);
        rise_q  <= (cnt_d == '0);
        fall_q  <= (cnt_d == hi_eff);
      end
      if (en && wrap) begin
        div_active_q <= d_eff;
        pend_vld_q   <= 1'b0;
      end else if (load_ok) begin
        pend_q     <= div_in;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign s_clk      = s_clk_q;
  assign rise_stb   = rise_q;
  assign fall_stb   = fall_q;
  assign div_active = div_active_q;
  assign div_err    = err_q;

endmodule

// File: tb/tb_programmable_sclk_divider.sv
// Directed vector bench for programmable_sclk_divider: one table row per clk edge,
// plus a hand-written sweep of the maximum divisor.
module tb_programmable_sclk_divider;

  logic       clk = 1'b0;
  logic       rst, en, div_load;
  logic [7:0] div_in;
  logic       s_clk, rise_stb, fall_stb, div_err;
  logic [7:0] div_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       rst, en, ld;
    bit [7:0] din;
    bit       s, r, f, e;
    bit [7:0] a;
  } vec_t;

  vec_t tv[$];

  programmable_sclk_divider #(.CNT_W(8), .DEFAULT_DIV(5)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .s_clk(s_clk), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .div_active(div_active), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic add(input bit r_, input bit en_, input bit [7:0] din_, input bit ld_,
                     input bit s_, input bit rs_, input bit f_, input bit [7:0] a_, input bit e_);
    vec_t v;
    v.rst = r_; v.en = en_; v.din = din_; v.ld = ld_;
    v.s = s_; v.r = rs_; v.f = f_; v.a = a_; v.e = e_;
    tv.push_back(v);
  endtask

  task automatic step(input bit r_, input bit en_, input bit [7:0] din_, input bit ld_);
    @(negedge clk);
    rst = r_; en = en_; div_in = din_; div_load = ld_;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int hi_cnt, fall_k, both;
    rst = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0;

    // reset, default D=5: 1,1,1,0,0
    add(1,0,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    add(0,1,0,0, 0,0,1,5,0);
    add(0,1,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    // load 4 at cnt=1: current period finishes at 5
    add(0,1,4,1, 1,0,0,5,0);
    add(0,1,0,0, 0,0,1,5,0);
    add(0,1,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,4,0);
    add(0,1,0,0, 1,0,0,4,0);
    add(0,1,0,0, 0,0,1,4,0);
    add(0,1,0,0, 0,0,0,4,0);
    add(0,1,0,0, 1,1,0,4,0);
    add(0,1,0,0, 1,0,0,4,0);
    add(0,1,0,0, 0,0,1,4,0);
    add(0,1,0,0, 0,0,0,4,0);
    // load 2 in the wrap cycle: applies immediately
    add(0,1,2,1, 1,1,0,2,0);
    add(0,1,0,0, 0,0,1,2,0);
    add(0,1,0,0, 1,1,0,2,0);
    add(0,1,0,0, 0,0,1,2,0);
    // pending 6 survives two rejected loads
    add(1,0,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,5,0);
    add(0,1,6,1, 1,0,0,5,0);
    add(0,1,0,1, 1,0,0,5,1);
    add(0,1,1,1, 0,0,1,5,1);
    add(0,1,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,6,0);
    add(0,1,0,0, 1,0,0,6,0);
    add(0,1,0,0, 1,0,0,6,0);
    add(0,1,0,0, 0,0,1,6,0);
    add(0,1,0,0, 0,0,0,6,0);
    add(0,1,0,0, 0,0,0,6,0);
    add(0,1,0,0, 1,1,0,6,0);
    // en=0 for 7 cycles at cnt=2, with a load of 4 while frozen
    add(1,0,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    add(0,0,0,0, 1,0,0,5,0);
    add(0,0,0,0, 1,0,0,5,0);
    add(0,0,4,1, 1,0,0,5,0);
    add(0,0,0,0, 1,0,0,5,0);
    add(0,0,0,0, 1,0,0,5,0);
    add(0,0,0,0, 1,0,0,5,0);
    add(0,0,0,0, 1,0,0,5,0);
    add(0,1,0,0, 0,0,1,5,0);
    add(0,1,0,0, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,4,0);
    add(0,1,0,0, 1,0,0,4,0);
    add(0,1,0,0, 0,0,1,4,0);
    add(0,1,0,0, 0,0,0,4,0);
    add(0,1,0,0, 1,1,0,4,0);
    // pending 3 discarded by reset; invalid load under reset gives no error
    add(0,1,3,1, 1,0,0,4,0);
    add(1,1,0,1, 0,0,0,5,0);
    add(0,1,0,0, 1,1,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    add(0,1,0,0, 1,0,0,5,0);
    add(0,1,0,0, 0,0,1,5,0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].en, tv[i].din, tv[i].ld);
      chk($sformatf("row%0d {s,r,f,err,div}", i),
          {20'd0, s_clk, rise_stb, fall_stb, div_err, div_active},
          {20'd0, tv[i].s, tv[i].r, tv[i].f, tv[i].e, tv[i].a});
    end

    // maximum divisor 255: 128 high, 127 low
    step(1, 0, 0, 0);
    step(0, 1, 8'd255, 1);
    chk("d255 first edge", {s_clk, rise_stb, div_active}, {1'b1, 1'b1, 8'd255});
    hi_cnt = 1; fall_k = -1; both = 0;
    for (int k = 1; k < 255; k++) begin
      step(0, 1, 0, 0);
      if (s_clk) hi_cnt++;
      if (fall_stb) fall_k = k;
      if ((rise_stb && fall_stb) || rise_stb) both++;
    end
    chk("d255 high cycles", hi_cnt, 128);
    chk("d255 fall position", fall_k, 128);
    chk("d255 no stray rise", both, 0);
    step(0, 1, 0, 0);
    chk("d255 wrap", {s_clk, rise_stb, fall_stb}, 3'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
